// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system control unit: TX FSM state encoding,
// default data width and command opcodes used by the receive FSM.
package sys_ctrl_pkg;

  localparam int unsigned WIDTH_DEF  = 8;
  localparam int unsigned DROP_W_DEF = 8;

  // TX response FSM encoding (2-bit binary)
  localparam logic [1:0] TX_IDLE_ENC    = 2'b00;
  localparam logic [1:0] TX_RF_SEND_ENC = 2'b01;
  localparam logic [1:0] TX_ALU_LSB_ENC = 2'b10;
  localparam logic [1:0] TX_ALU_MSB_ENC = 2'b11;

  typedef enum logic [1:0] {
    TX_IDLE    = TX_IDLE_ENC,
    TX_RF_SEND = TX_RF_SEND_ENC,
    TX_ALU_LSB = TX_ALU_LSB_ENC,
    TX_ALU_MSB = TX_ALU_MSB_ENC
  } tx_state_e;

  // Command opcodes shared with the command-path receive FSM
  localparam logic [7:0] CMD_RF_WR    = 8'hAA;
  localparam logic [7:0] CMD_RF_RD    = 8'hBB;
  localparam logic [7:0] CMD_ALU_OP   = 8'hCC;
  localparam logic [7:0] CMD_ALU_NOOP = 8'hDD;

endpackage

// File: rtl/sys_tx_fsm_if.sv
// Response-path bundle between register file/ALU, TX FIFO write port and the
// TX FSM. The slave modport is the FSM side.
interface sys_tx_fsm_if
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned Width  = WIDTH_DEF,
  parameter int unsigned Drop_W = DROP_W_DEF
);

  logic [Width-1:0]   RdData;
  logic               RdData_Valid;
  logic [2*Width-1:0] ALU_OUT;
  logic               OUT_Valid;
  logic               FIFO_FULL;
  logic [Width-1:0]   WR_DATA;
  logic               WR_INC;
  logic               TX_BUSY;
  logic [Drop_W-1:0]  Drop_Cnt;

  modport master (
    output RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
    input  WR_DATA, WR_INC, TX_BUSY, Drop_Cnt
  );

  modport slave (
    input  RdData, RdData_Valid, ALU_OUT, OUT_Valid, FIFO_FULL,
    output WR_DATA, WR_INC, TX_BUSY, Drop_Cnt
  );

endinterface

// File: rtl/sys_tx_fsm.sv
// Serialises register-file reads and 16-bit ALU results into TX FIFO bytes.
// Optional dropped-response counter enabled by SYS_TX_DROP_CNT_EN.
module sys_tx_fsm
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned Width  = WIDTH_DEF,
  parameter int unsigned Drop_W = DROP_W_DEF
) (
  input  logic        CLK,
  input  logic        RST,
  sys_tx_fsm_if.slave bus
);

  tx_state_e          state_q, state_d;
  logic [2*Width-1:0] buf_q, buf_d;
  logic               wr_inc_c;
  logic [Width-1:0]   wr_data_c;
  logic               accept_c;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= TX_IDLE;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
    end
  end

  // Next state, push decode and capture; accept_c marks cycles where strobes are taken
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    wr_inc_c  = 1'b0;
    wr_data_c = buf_q[Width-1:0];
    accept_c  = 1'b0;

    case (state_q)
      TX_IDLE: accept_c = 1'b1;
      TX_RF_SEND: begin
        wr_inc_c = !bus.FIFO_FULL;
        if (wr_inc_c) begin
          state_d  = TX_IDLE;
          accept_c = 1'b1;
        end
      end
      TX_ALU_LSB: begin
        wr_inc_c = !bus.FIFO_FULL;
        if (wr_inc_c) state_d = TX_ALU_MSB;
      end
      TX_ALU_MSB: begin
        wr_data_c = buf_q[2*Width-1:Width];
        wr_inc_c  = !bus.FIFO_FULL;
        if (wr_inc_c) begin
          state_d  = TX_IDLE;
          accept_c = 1'b1;
        end
      end
      default: state_d = TX_IDLE;
    endcase

    // Register read wins over a simultaneous ALU result
    if (accept_c) begin
      if (bus.RdData_Valid) begin
        buf_d[Width-1:0] = bus.RdData;
        state_d          = TX_RF_SEND;
      end else if (bus.OUT_Valid) begin
        buf_d   = bus.ALU_OUT;
        state_d = TX_ALU_LSB;
      end
    end
  end

  assign bus.WR_INC  = wr_inc_c;
  assign bus.WR_DATA = wr_data_c;
  assign bus.TX_BUSY = (state_q != TX_IDLE);

`ifdef SYS_TX_DROP_CNT_EN
  logic [Drop_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [1:0]        drop_inc_c;
  logic [Drop_W:0]   drop_sum_c;

  // Up to two drops per cycle; sum carries one extra bit to detect saturation
  always_comb begin
    drop_inc_c = 2'd0;
    if (accept_c)
      drop_inc_c = (bus.RdData_Valid && bus.OUT_Valid) ? 2'd1 : 2'd0;
    else
      drop_inc_c = 2'(bus.RdData_Valid) + 2'(bus.OUT_Valid);
    drop_sum_c = {1'b0, drop_cnt_q} + (Drop_W+1)'(drop_inc_c);
    drop_cnt_d = drop_sum_c[Drop_W] ? '1 : drop_sum_c[Drop_W-1:0];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign bus.Drop_Cnt = drop_cnt_q;
`else
  assign bus.Drop_Cnt = Drop_W'(0);
`endif

endmodule

// File: doc/sys_tx_fsm.md
# sys_tx_fsm

Response-path controller of the system control unit. It captures register-file read data and 16-bit ALU results, serialises them into bytes, and pushes those bytes into the TX async FIFO, which feeds the UART transmitter. It sits between the register file/ALU and the FIFO write port, alongside the command-path receive FSM, and reports busy so that responses are never interleaved.

## Interface
Parameters:
- Width, 8, byte and register data width
- Drop_W, 8, width of the dropped-response counter

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- RdData  in  Width  register-file read data
- RdData_Valid  in  1  one-cycle strobe; RdData is valid
- ALU_OUT  in  2*Width  ALU result
- OUT_Valid  in  1  one-cycle strobe; ALU_OUT is valid
- FIFO_FULL  in  1  TX FIFO full, synchronised to CLK
- WR_DATA  out  Width  FIFO write data
- WR_INC  out  1  FIFO push strobe; one byte per high cycle
- TX_BUSY  out  1  high while a response is pending
- Drop_Cnt  out  Drop_W  saturating count of dropped responses

## Operation
- States: IDLE, RF_SEND, ALU_LSB, ALU_MSB. State encoding is 2-bit binary.
- Holding buffer Buf is 2*Width bits, registered.
- IDLE:
  - If RdData_Valid: Buf[Width-1:0] <= RdData, then go to RF_SEND.
  - Else if OUT_Valid: Buf <= ALU_OUT, then go to ALU_LSB.
  - Else stay in IDLE.
- Simultaneous RdData_Valid and OUT_Valid: RdData wins and the ALU result is dropped.
- Send states:
  - WR_INC = !FIFO_FULL.
  - WR_DATA = Buf[Width-1:0] in RF_SEND and ALU_LSB; Buf[2*Width-1:Width] in ALU_MSB.
  - Advance only on an edge where WR_INC is high.
  - RF_SEND goes to IDLE. ALU_LSB goes to ALU_MSB. ALU_MSB goes to IDLE.
- FIFO_FULL high: hold the state, WR_INC=0. WR_DATA stays stable while holding.
- Final push (RF_SEND or ALU_MSB with WR_INC=1): valid strobes in that same cycle are accepted with IDLE priority rules. The FSM goes straight to RF_SEND or ALU_LSB with no bubble.
- Drops: a valid strobe that arrives in a send-state cycle other than a final-push cycle is dropped, and Drop_Cnt increments by one.
  - Two strobes in one such cycle count as 2.
  - A losing strobe in a simultaneous-capture cycle counts as 1.
  - Drop_Cnt saturates at all-ones.
- TX_BUSY = (state != IDLE), combinational.
- WR_INC and WR_DATA are decoded combinationally from the state, Buf and FIFO_FULL. There is no glitch requirement beyond single-clock use.

## Timing
- Reset values: state IDLE, Buf 0, WR_INC 0, WR_DATA 0, TX_BUSY 0, Drop_Cnt 0.
- RF latency: strobe at edge k gives WR_INC high in cycle k..k+1, with the push at edge k+1 if the FIFO is not full.
- ALU latency: LSB pushed at edge k+1, MSB at edge k+2, back-to-back when the FIFO is not full.
- Each FIFO_FULL cycle inserts exactly one stall cycle. No byte is lost or duplicated.
- Reset mid-operation aborts the transfer. The partial response is discarded, with no MSB-only push afterwards.
- Throughput: one byte per cycle sustained.

## Configuration
- SYS_TX_DROP_CNT_EN defined:
  - The counter logic is instantiated and Drop_Cnt behaves as in Operation.
- SYS_TX_DROP_CNT_EN undefined:
  - The counter is absent and Drop_Cnt is tied to 0.
  - Drop behaviour itself is unchanged: dropped responses are still discarded silently.

## Structure
- Shared package sys_ctrl_pkg holds:
  - the TX state encoding localparams
  - the default Width
  - command opcode constants shared with the receive FSM: 8'hAA, 8'hBB, 8'hCC, 8'hDD
- No sub-module: the FSM, Buf and the counter are a single flat module.

## Test plan
- RdData=8'h5A strobe, FIFO_FULL=0 → exactly one WR_INC, WR_DATA=8'h5A on the next cycle, TX_BUSY high for 1 cycle.
- ALU_OUT=16'hBEEF strobe → pushes 8'hEF then 8'hBE on consecutive cycles, then IDLE.
- ALU_OUT=16'h1234 with FIFO_FULL high for 3 cycles starting at the LSB cycle → WR_INC low for 3 cycles, then 8'h34 and 8'h12 in order, no duplicates.
- RdData_Valid and OUT_Valid in the same cycle (8'h11, 16'h2233) → only 8'h11 is pushed. With the macro on, Drop_Cnt=1.
- New RdData=8'h77 strobe during the final-push cycle of a prior RF response → 8'h77 is pushed on the next cycle, no IDLE bubble. A strobe during the ALU_LSB cycle is dropped and counted. Drop_Cnt saturates at 8'hFF after 300 drops.
- RST asserted in ALU_MSB with FIFO_FULL high → all outputs return to reset values. After release, no MSB byte is pushed.
